// File: rtl/jtpang_snd_pkg.sv
// Shared definitions for the Pang sound section: PCM cache FSM states and defaults.
package jtpang_snd_pkg;

    localparam int PCM_AW    = 18;
    localparam int PCM_LINES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2
    } pcm_state_e;

endpackage

// File: rtl/jtpang_pcm_line.sv
// One fully-associative cache line: tag, valid bit, 32-bit data, hit compare and byte select.
module jtpang_pcm_line
    import jtpang_snd_pkg::*;
#(
    parameter int TW = PCM_AW - 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic          wr_valid,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data,
    input  logic [TW-1:0] rd_tag,
    input  logic [1:0]    rd_sel,
    output logic          hit,
    output logic [7:0]    rd_byte
);

    logic          valid_reg;
    logic [TW-1:0] tag_reg;
    logic [31:0]   data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else begin
            if (flush)
                valid_reg <= 1'b0;
            else if (wr_en)
                valid_reg <= wr_valid;
            if (wr_en) begin
                tag_reg  <= wr_tag;
                data_reg <= wr_data;
            end
        end
    end

    assign hit = valid_reg && (tag_reg == rd_tag);

    always_comb begin
        rd_byte = data_reg[7:0];
        case (rd_sel)
            2'd0: rd_byte = data_reg[7:0];
            2'd1: rd_byte = data_reg[15:8];
            2'd2: rd_byte = data_reg[23:16];
            2'd3: rd_byte = data_reg[31:24];
            default: rd_byte = data_reg[7:0];
        endcase
    end

endmodule

// File: rtl/jtpang_pcm_cache.sv
// Small read cache between the jt6295 ROM port and the SDRAM slot: 4-byte lines,
// one-cycle hits, two-word SDRAM refill on a miss, round-robin replacement.
module jtpang_pcm_cache
    import jtpang_snd_pkg::*;
#(
    parameter int AW    = PCM_AW,
    parameter int LINES = PCM_LINES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [AW-1:0] pcm_addr,
    output logic [7:0]    pcm_data,
    output logic          pcm_ok,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic [15:0]   sdram_data,
    input  logic          sdram_ok
);

    localparam int TW = AW - 2;
    localparam int VW = (LINES > 1) ? $clog2(LINES) : 1;

    pcm_state_e    state_reg;
    logic [TW-1:0] base_reg;
    logic [VW-1:0] victim_reg;
    logic [15:0]   lo_reg;
    logic          flush_seen_reg;
    logic          ok_reg;
    logic [7:0]    data_reg;
    logic [AW-1:0] addr_reg;
    logic [AW-2:0] sdram_addr_reg;
    logic          sdram_req_reg;

    logic [LINES-1:0] hit_vec;
    logic [7:0]       byte_arr [LINES];
    logic             any_hit;
    logic [7:0]       hit_byte;
    logic             fill_done;
    logic             line_valid;

    assign fill_done  = (state_reg == FILL1) && sdram_ok;
    // A flush seen at any point of the fill, including the completing cycle, poisons the line.
    assign line_valid = !flush_seen_reg && !flush;

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            jtpang_pcm_line #(.TW(TW)) u_line (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .wr_en    (fill_done && (victim_reg == VW'(gi))),
                .wr_valid (line_valid),
                .wr_tag   (base_reg),
                .wr_data  ({sdram_data, lo_reg}),
                .rd_tag   (pcm_addr[AW-1:2]),
                .rd_sel   (pcm_addr[1:0]),
                .hit      (hit_vec[gi]),
                .rd_byte  (byte_arr[gi])
            );
        end
    endgenerate

    // Tags are unique across valid lines, so OR-ing the gated bytes is a clean mux.
    always_comb begin
        hit_byte = 8'd0;
        for (int i = 0; i < LINES; i++) begin
            if (hit_vec[i])
                hit_byte = hit_byte | byte_arr[i];
        end
    end

    assign any_hit = |hit_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            victim_reg     <= '0;
            lo_reg         <= '0;
            flush_seen_reg <= 1'b0;
            ok_reg         <= 1'b0;
            data_reg       <= '0;
            addr_reg       <= '0;
            sdram_addr_reg <= '0;
            sdram_req_reg  <= 1'b0;
        end else begin
            ok_reg <= any_hit && !flush;
            if (any_hit) begin
                data_reg <= hit_byte;
                addr_reg <= pcm_addr;
            end
            case (state_reg)
                IDLE: begin
                    flush_seen_reg <= 1'b0;
                    if (!any_hit && !flush) begin
                        base_reg       <= pcm_addr[AW-1:2];
                        sdram_addr_reg <= {pcm_addr[AW-1:2], 1'b0};
                        sdram_req_reg  <= 1'b1;
                        state_reg      <= FILL0;
                    end
                end
                FILL0: begin
                    if (flush)
                        flush_seen_reg <= 1'b1;
                    if (sdram_ok) begin
                        lo_reg         <= sdram_data;
                        sdram_addr_reg <= {base_reg, 1'b1};
                        state_reg      <= FILL1;
                    end
                end
                FILL1: begin
                    if (flush)
                        flush_seen_reg <= 1'b1;
                    if (sdram_ok) begin
                        sdram_req_reg <= 1'b0;
                        victim_reg    <= victim_reg + VW'(1);
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pcm_data   = data_reg;
    assign pcm_ok     = ok_reg && (pcm_addr == addr_reg);
    assign sdram_addr = sdram_addr_reg;
    assign sdram_req  = sdram_req_reg;

endmodule

// File: tb/tb_jtpang_pcm_cache.sv
// Bench for jtpang_pcm_cache: table vectors, hand-written fill corner cases and
// randomized reads checked against a simple slot/pointer cache model.
module tb_jtpang_pcm_cache;

    localparam int AW    = 18;
    localparam int LINES = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [AW-1:0] pcm_addr;
    logic [7:0]    pcm_data;
    logic          pcm_ok;
    logic [AW-2:0] sdram_addr;
    logic          sdram_req;
    logic [15:0]   sdram_data;
    logic          sdram_ok;

    jtpang_pcm_cache #(.AW(AW), .LINES(LINES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .pcm_addr   (pcm_addr),
        .pcm_data   (pcm_data),
        .pcm_ok     (pcm_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_data (sdram_data),
        .sdram_ok   (sdram_ok)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // ROM contents: bytes 4..7 fixed for the cold-miss vector, everything else hashed.
    function automatic logic [7:0] rom_byte(input int a);
        case (a)
            4: rom_byte = 8'hAA;
            5: rom_byte = 8'hBB;
            6: rom_byte = 8'hCC;
            7: rom_byte = 8'hDD;
            default: rom_byte = 8'(((a * 37) + (a >> 3)) ^ 8'h3C);
        endcase
    endfunction

    function automatic logic [15:0] rom_word(input int w);
        rom_word = {rom_byte(2 * w + 1), rom_byte(2 * w)};
    endfunction

    // SDRAM model: answers each requested word three cycles after it is presented.
    logic [AW-2:0] fetch_q[$];
    int            lat_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            sdram_ok = 1'b0;
            lat_cnt  = 0;
        end else if (sdram_ok) begin
            sdram_ok = 1'b0;
            lat_cnt  = 0;
        end else if (sdram_req) begin
            lat_cnt++;
            if (lat_cnt == 3) begin
                sdram_ok   = 1'b1;
                sdram_data = rom_word(int'(sdram_addr));
                fetch_q.push_back(sdram_addr);
            end
        end
    end

    function automatic longint fq(input int i);
        fq = (i < fetch_q.size()) ? longint'(fetch_q[i]) : -1;
    endfunction

    // Reference cache: LINES slots filled in rotation, a fill only on a miss.
    bit m_valid[LINES];
    int m_tag[LINES];
    int m_ptr;

    function automatic void m_flush();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_flush();
        m_ptr = 0;
    endfunction

    function automatic bit m_lookup(input int a);
        m_lookup = 1'b0;
        for (int i = 0; i < LINES; i++)
            if (m_valid[i] && m_tag[i] == (a >> 2)) m_lookup = 1'b1;
    endfunction

    function automatic void m_fill(input int a);
        m_tag[m_ptr]   = a >> 2;
        m_valid[m_ptr] = 1'b1;
        m_ptr          = (m_ptr + 1) % LINES;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic access(input int a, input bit exp_hit, input string name);
        int cycles;
        bit got;
        bit req_seen;
        fetch_q.delete();
        pcm_addr = AW'(a);
        cycles   = 0;
        got      = 1'b0;
        req_seen = 1'b0;
        while (!got && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (sdram_req) req_seen = 1'b1;
            if (pcm_ok) got = 1'b1;
        end
        chk($sformatf("%s ok @%0h", name, a), got, 1);
        chk($sformatf("%s data @%0h", name, a), pcm_data, rom_byte(a));
        if (exp_hit) begin
            chk($sformatf("%s hit latency @%0h", name, a), cycles, 1);
            chk($sformatf("%s hit req @%0h", name, a), req_seen, 0);
        end else begin
            chk($sformatf("%s fetches @%0h", name, a), fetch_q.size(), 2);
            chk($sformatf("%s word0 @%0h", name, a), fq(0), (a >> 2) * 2);
            chk($sformatf("%s word1 @%0h", name, a), fq(1), (a >> 2) * 2 + 1);
        end
        if (!m_lookup(a)) m_fill(a);
        $display("access %-10s addr=%05h hit_exp=%0d cycles=%0d data=%02h", name, a, exp_hit, cycles, pcm_data);
    endtask

    typedef struct {
        bit do_reset;
        int addr;
        bit exp_hit;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int  cyc;
        int  bad;
        bit  got;

        tbl[0]  = '{1'b1, 0,     1'b0};
        tbl[1]  = '{1'b0, 'h05,  1'b0};
        tbl[2]  = '{1'b0, 'h04,  1'b1};
        tbl[3]  = '{1'b0, 'h05,  1'b1};
        tbl[4]  = '{1'b0, 'h06,  1'b1};
        tbl[5]  = '{1'b0, 'h07,  1'b1};
        tbl[6]  = '{1'b1, 0,     1'b0};
        tbl[7]  = '{1'b0, 'h00,  1'b0};
        tbl[8]  = '{1'b0, 'h10,  1'b0};
        tbl[9]  = '{1'b0, 'h20,  1'b0};
        tbl[10] = '{1'b0, 'h30,  1'b0};
        tbl[11] = '{1'b0, 'h40,  1'b0};
        tbl[12] = '{1'b0, 'h10,  1'b1};
        tbl[13] = '{1'b0, 'h00,  1'b0};
        tbl[14] = '{1'b0, 'h20,  1'b1};
        tbl[15] = '{1'b0, 'h10,  1'b0};

        rst_n    = 1'b1;
        flush    = 1'b0;
        pcm_addr = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset pcm_data", pcm_data, 0);
        chk("reset pcm_ok", pcm_ok, 0);
        chk("reset sdram_req", sdram_req, 0);
        chk("reset sdram_addr", sdram_addr, 0);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].do_reset) do_reset();
            else access(tbl[i].addr, tbl[i].exp_hit, "table");
        end

        // Address moves to another line while the first fill is in FILL0.
        do_reset();
        fetch_q.delete();
        pcm_addr = AW'('h100);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (sdram_req) got = 1'b1;
        end
        chk("midfill req start", got, 1);
        pcm_addr = AW'('h104);
        bad = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (pcm_ok) begin
                got = 1'b1;
                if (pcm_data != rom_byte('h104)) bad++;
            end
        end
        chk("midfill ok", got, 1);
        chk("midfill stale data", bad, 0);
        chk("midfill fetch count", fetch_q.size(), 4);
        chk("midfill first line", fq(1), 'h81);
        chk("midfill second line", fq(2), 'h82);
        $display("midfill    addr=00104 fetches=%0d data=%02h", fetch_q.size(), pcm_data);
        m_fill('h100);
        m_fill('h104);
        access('h100, 1'b1, "midfill");
        pcm_addr = AW'('h101);
        #1;
        chk("comb ok drop", pcm_ok, 0);
        @(posedge clk);
        #1;
        chk("same-line hit ok", pcm_ok, 1);
        chk("same-line hit data", pcm_data, rom_byte('h101));

        // Flush pulse while the second word is outstanding.
        do_reset();
        access('h08, 1'b0, "preflush");
        fetch_q.delete();
        pcm_addr = AW'('h200);
        for (int i = 0; i < 50 && fetch_q.size() == 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("flush reach fill1", fetch_q.size(), 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush req held", sdram_req, 1);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pcm_ok) got = 1'b1;
        end
        chk("flush refetch ok", got, 1);
        chk("flush refetch data", pcm_data, rom_byte('h200));
        chk("flush refetch count", fetch_q.size(), 4);
        $display("flushfill  addr=00200 fetches=%0d data=%02h", fetch_q.size(), pcm_data);
        m_reset();
        m_fill('h200);
        access('h08, 1'b0, "postflush");

        // Asynchronous reset in the middle of FILL0.
        do_reset();
        fetch_q.delete();
        pcm_addr = AW'('h300);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (sdram_req) got = 1'b1;
        end
        chk("arst req start", got, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst sdram_req", sdram_req, 0);
        chk("arst pcm_ok", pcm_ok, 0);
        chk("arst sdram_addr", sdram_addr, 0);
        $display("arst       addr=00300 req=%0d ok=%0d", sdram_req, pcm_ok);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        access('h300, 1'b0, "postarst");

        // Randomized reads over a small window so hits and evictions both occur.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            int  a;
            bit  e;
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                m_flush();
            end
            a = int'($urandom_range(0, 95));
            e = m_lookup(a);
            access(a, e, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
